muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Sits beside the ALU in the execute stage.
- Accepts one operation per start pulse and runs it iteratively at 1 bit per cycle.
- Drives busy/done handshakes and generates the stall interlock for HI/LO reads and writes.

---
 rtl/muldiv_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers.
//
// Runs MULT/MULTU/DIV/DIVU one bit per cycle: shift-add for multiply, restoring
// division for divide. Signed operations work on magnitudes and fix the result
// signs in a final FIX cycle. Also serves MFHI/MFLO/MTHI/MTLO and raises the
// stall interlock while an operation is in flight.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   When defined, MULT/MULTU skip CALC and use one combinational multiplier
//   (busy for one cycle, done in cycle 2). Divide is unaffected.
//
// Ports:
//   w_clk, w_rst_n        clock, asynchronous active-low reset
//   w_start, w_op_code_6  start request and SPECIAL funct code
//   w_input1_x/2_x        rs (multiplicand/dividend), rt (multiplier/divisor)
//   w_busy, w_done        operation in progress / one-cycle result pulse
//   w_div_zero            sticky divide-by-zero flag, cleared on next start
//   w_read_hi/lo          MFHI/MFLO requests (only affect w_stall)
//   w_write_hi/lo, w_wdata_x  MTHI/MTLO requests and data
//   w_hi_x, w_lo_x        HI/LO register values
//   w_stall               busy and any HI/LO access requested
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             w_clk,
   input  logic             w_rst_n,
   input  logic             w_start,
   input  logic [5:0]       w_op_code_6,
   input  logic [WIDTH-1:0] w_input1_x,
   input  logic [WIDTH-1:0] w_input2_x,
   output logic             w_busy,
   output logic             w_done,
   output logic             w_div_zero,
   input  logic             w_read_hi,
   input  logic             w_read_lo,
   input  logic             w_write_hi,
   input  logic             w_write_lo,
   input  logic [WIDTH-1:0] w_wdata_x,
   output logic [WIDTH-1:0] w_hi_x,
   output logic [WIDTH-1:0] w_lo_x,
   output logic             w_stall
);

   // SPECIAL funct encodings, matching isa_codes.v
   localparam logic [5:0] OpMult  = 6'h18;
   localparam logic [5:0] OpMultu = 6'h19;
   localparam logic [5:0] OpDiv   = 6'h1A;
   localparam logic [5:0] OpDivu  = 6'h1B;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   // Multiplicand magnitude or divisor magnitude.
   logic [WIDTH-1:0]       opnd_q, opnd_d;
   logic                   is_div_q, is_div_d;
   logic                   sign1_q, sign1_d;
   logic                   sign2_q, sign2_d;
   logic [WIDTH-1:0]       hi_q, hi_d;
   logic [WIDTH-1:0]       lo_q, lo_d;
   logic                   done_q, done_d;
   logic                   div_zero_q, div_zero_d;

   logic                   op_valid;
   logic                   op_signed;
   logic                   in_sign1, in_sign2;
   logic [WIDTH-1:0]       mag1, mag2;
   logic [WIDTH:0]         add_sum;
   logic [WIDTH:0]         rem_ext;
   logic [WIDTH:0]         trial;
   logic [2*WIDTH-1:0]     prod_fix;
   logic [WIDTH-1:0]       quot_fix, rem_fix;

   assign op_valid  = (w_op_code_6 == OpMult) || (w_op_code_6 == OpMultu) ||
                      (w_op_code_6 == OpDiv)  || (w_op_code_6 == OpDivu);
   assign op_signed = ~w_op_code_6[0];
   assign in_sign1  = op_signed & w_input1_x[WIDTH-1];
   assign in_sign2  = op_signed & w_input2_x[WIDTH-1];
   assign mag1      = in_sign1 ? -w_input1_x : w_input1_x;
   assign mag2      = in_sign2 ? -w_input2_x : w_input2_x;

   // Shift-add step: add multiplicand into the upper half when multiplier LSB set.
   assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

   // Restoring step: remainder after the left shift needs one extra bit.
   assign rem_ext = acc_q[2*WIDTH-1:WIDTH-1];
   assign trial   = rem_ext - {1'b0, opnd_q};

   // Sign flags are only ever set for signed ops.
   assign prod_fix = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
   assign quot_fix = (sign1_q ^ sign2_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = sign1_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      sign1_d    = sign1_q;
      sign2_d    = sign2_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;

      case (state_q)
         StIdle: begin
            if (w_start && op_valid) begin
               is_div_d   = w_op_code_6[1];
               sign1_d    = in_sign1;
               sign2_d    = in_sign2;
               cnt_d      = CNT_W'(WIDTH);
               div_zero_d = 1'b0;
               state_d    = StCalc;
               if (w_op_code_6[1]) begin
                  acc_d  = {{WIDTH{1'b0}}, mag1};
                  opnd_d = mag2;
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  acc_d   = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
                  opnd_d  = mag1;
                  state_d = StFix;
`else
                  acc_d  = {{WIDTH{1'b0}}, mag2};
                  opnd_d = mag1;
`endif
               end
            end
         end
         StCalc: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (is_div_q) begin
               if (trial[WIDTH]) begin
                  acc_d = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end else begin
                  acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               end
            end else begin
               acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end
            if (cnt_q == CNT_W'(1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (is_div_q) begin
               // With a zero divisor every trial succeeds, so the remainder ends up
               // holding the dividend magnitude and the quotient all ones.
               hi_d = rem_fix;
               if (opnd_q == '0) begin
                  lo_d       = '1;
                  div_zero_d = 1'b1;
               end else begin
                  lo_d = quot_fix;
               end
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         default: state_d = StIdle;
      endcase

      // MTHI/MTLO only take effect when idle; this includes the done cycle.
      if (state_q == StIdle) begin
         if (w_write_hi) hi_d = w_wdata_x;
         if (w_write_lo) lo_d = w_wdata_x;
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         sign1_q    <= 1'b0;
         sign2_q    <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         sign1_q    <= sign1_d;
         sign2_q    <= sign2_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign w_busy     = (state_q != StIdle);
   assign w_done     = done_q;
   assign w_div_zero = div_zero_q;
   assign w_hi_x     = hi_q;
   assign w_lo_x     = lo_q;
   assign w_stall    = w_busy & (w_read_hi | w_read_lo | w_write_hi | w_write_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (default build).
// Inputs change just after the falling edge; outputs are sampled on it.
module tb_muldiv_sequencer;

   localparam int unsigned WIDTH = 32;
   localparam logic [5:0] OpMult  = 6'h18;
   localparam logic [5:0] OpMultu = 6'h19;
   localparam logic [5:0] OpDiv   = 6'h1A;
   localparam logic [5:0] OpDivu  = 6'h1B;

   logic             w_clk;
   logic             w_rst_n;
   logic             w_start;
   logic [5:0]       w_op_code_6;
   logic [WIDTH-1:0] w_input1_x;
   logic [WIDTH-1:0] w_input2_x;
   logic             w_busy;
   logic             w_done;
   logic             w_div_zero;
   logic             w_read_hi;
   logic             w_read_lo;
   logic             w_write_hi;
   logic             w_write_lo;
   logic [WIDTH-1:0] w_wdata_x;
   logic [WIDTH-1:0] w_hi_x;
   logic [WIDTH-1:0] w_lo_x;
   logic             w_stall;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) u_dut (
      .w_clk       (w_clk),
      .w_rst_n     (w_rst_n),
      .w_start     (w_start),
      .w_op_code_6 (w_op_code_6),
      .w_input1_x  (w_input1_x),
      .w_input2_x  (w_input2_x),
      .w_busy      (w_busy),
      .w_done      (w_done),
      .w_div_zero  (w_div_zero),
      .w_read_hi   (w_read_hi),
      .w_read_lo   (w_read_lo),
      .w_write_hi  (w_write_hi),
      .w_write_lo  (w_write_lo),
      .w_wdata_x   (w_wdata_x),
      .w_hi_x      (w_hi_x),
      .w_lo_x      (w_lo_x),
      .w_stall     (w_stall)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a start for one edge; returns at the sample point of cycle 1.
   task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      w_start     = 1'b1;
      w_op_code_6 = op;
      w_input1_x  = a;
      w_input2_x  = b;
      @(negedge w_clk);
      w_start = 1'b0;
   endtask

   // Waits (bounded) for w_done, checks it lands in cycle WIDTH+2.
   task automatic wait_done(input string tag);
      int cyc;
      cyc = 1;
      while (!w_done && cyc < 200) begin
         @(negedge w_clk);
         cyc++;
      end
      check_eq({tag, "_done"}, {63'd0, w_done}, 64'd1);
      check_eq({tag, "_lat"}, 64'(cyc), 64'(WIDTH + 2));
   endtask

   initial begin
      w_rst_n     = 1'b0;
      w_start     = 1'b0;
      w_op_code_6 = '0;
      w_input1_x  = '0;
      w_input2_x  = '0;
      w_read_hi   = 1'b0;
      w_read_lo   = 1'b0;
      w_write_hi  = 1'b0;
      w_write_lo  = 1'b0;
      w_wdata_x   = '0;

      // Reset state, with an access request pending
      w_read_hi = 1'b1;
      @(negedge w_clk);
      @(negedge w_clk);
      check_eq("rst_hi", 64'(w_hi_x), 64'd0);
      check_eq("rst_lo", 64'(w_lo_x), 64'd0);
      check_eq("rst_busy", {63'd0, w_busy}, 64'd0);
      check_eq("rst_done", {63'd0, w_done}, 64'd0);
      check_eq("rst_dz", {63'd0, w_div_zero}, 64'd0);
      check_eq("rst_stall", {63'd0, w_stall}, 64'd0);
      w_read_hi = 1'b0;
      w_rst_n   = 1'b1;
      @(negedge w_clk);

      // Invalid opcode is ignored
      start_op(6'h20, 32'd1, 32'd2);
      check_eq("badop_busy", {63'd0, w_busy}, 64'd0);

      // MULT -3 * 5
      start_op(OpMult, 32'hFFFF_FFFD, 32'h0000_0005);
      check_eq("mult_busy1", {63'd0, w_busy}, 64'd1);
      wait_done("mult");
      check_eq("mult_hi", 64'(w_hi_x), 64'hFFFF_FFFF);
      check_eq("mult_lo", 64'(w_lo_x), 64'hFFFF_FFF1);
      check_eq("mult_busy_done", {63'd0, w_busy}, 64'd0);

      // MULTU max * max, started in the previous done cycle
      start_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_eq("multu_done_lo", {63'd0, w_done}, 64'd0);
      wait_done("multu");
      check_eq("multu_hi", 64'(w_hi_x), 64'hFFFF_FFFE);
      check_eq("multu_lo", 64'(w_lo_x), 64'h0000_0001);

      // DIV -7 / 2
      start_op(OpDiv, 32'hFFFF_FFF9, 32'h0000_0002);
      wait_done("div");
      check_eq("div_hi", 64'(w_hi_x), 64'hFFFF_FFFF);
      check_eq("div_lo", 64'(w_lo_x), 64'hFFFF_FFFD);

      // DIV overflow case
      start_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("divovf");
      check_eq("divovf_hi", 64'(w_hi_x), 64'h0);
      check_eq("divovf_lo", 64'(w_lo_x), 64'h8000_0000);
      check_eq("divovf_dz", {63'd0, w_div_zero}, 64'd0);

      // DIVU by zero
      start_op(OpDivu, 32'd7, 32'd0);
      wait_done("divz");
      check_eq("divz_hi", 64'(w_hi_x), 64'd7);
      check_eq("divz_lo", 64'(w_lo_x), 64'hFFFF_FFFF);
      check_eq("divz_dz", {63'd0, w_div_zero}, 64'd1);

      // Signed DIV by zero of a negative dividend returns it unchanged
      start_op(OpDiv, 32'hFFFF_FF00, 32'd0);
      check_eq("dz_clear_on_start", {63'd0, w_div_zero}, 64'd0);
      wait_done("sdivz");
      check_eq("sdivz_hi", 64'(w_hi_x), 64'hFFFF_FF00);
      check_eq("sdivz_lo", 64'(w_lo_x), 64'hFFFF_FFFF);

      // Next start clears the flag
      start_op(OpMultu, 32'd2, 32'd3);
      check_eq("dz_clear", {63'd0, w_div_zero}, 64'd0);
      wait_done("multu_small");
      check_eq("multu_small_lo", 64'(w_lo_x), 64'd6);

      // Stall, ignored start, ignored MTHI while busy, MTLO in done cycle
      start_op(OpMult, 32'd3, 32'd4);
      for (int cyc = 1; cyc <= 34; cyc++) begin
         if (cyc >= 5 && cyc <= 33) check_eq($sformatf("stall_c%0d", cyc), {63'd0, w_stall}, 64'd1);
         if (cyc == 34) begin
            check_eq("stall_done_c34", {63'd0, w_stall}, 64'd0);
            check_eq("done_c34", {63'd0, w_done}, 64'd1);
            check_eq("res_lo_c34", 64'(w_lo_x), 64'd12);
         end
         if (cyc == 4) w_read_lo = 1'b1;
         if (cyc == 9) begin
            w_start     = 1'b1;
            w_op_code_6 = OpMultu;
            w_input1_x  = 32'hFFFF_FFFF;
            w_input2_x  = 32'hFFFF_FFFF;
         end
         if (cyc == 10) w_start = 1'b0;
         if (cyc == 19) begin
            w_write_hi = 1'b1;
            w_wdata_x  = 32'hDEAD;
         end
         if (cyc == 20) w_write_hi = 1'b0;
         if (cyc == 34) begin
            w_write_lo = 1'b1;
            w_wdata_x  = 32'h1234;
         end
         if (cyc < 34) @(negedge w_clk);
      end
      @(negedge w_clk);
      check_eq("mtlo_lo", 64'(w_lo_x), 64'h1234);
      check_eq("mthi_busy_ignored", 64'(w_hi_x), 64'd0);
      check_eq("no_second_done", {63'd0, w_done}, 64'd0);
      check_eq("ignored_start_idle", {63'd0, w_busy}, 64'd0);
      w_write_lo = 1'b0;
      w_read_lo  = 1'b0;
      @(negedge w_clk);

      // Reset in the middle of a DIVU
      start_op(OpDivu, 32'd100, 32'd7);
      for (int cyc = 1; cyc < 12; cyc++) @(negedge w_clk);
      w_rst_n = 1'b0;
      #1;
      check_eq("mrst_busy", {63'd0, w_busy}, 64'd0);
      check_eq("mrst_hi", 64'(w_hi_x), 64'd0);
      check_eq("mrst_lo", 64'(w_lo_x), 64'd0);
      check_eq("mrst_done", {63'd0, w_done}, 64'd0);
      @(negedge w_clk);
      check_eq("mrst_done2", {63'd0, w_done}, 64'd0);
      w_rst_n = 1'b1;
      @(negedge w_clk);
      check_eq("mrst_done3", {63'd0, w_done}, 64'd0);
      start_op(OpDivu, 32'd100, 32'd7);
      wait_done("divu_after_rst");
      check_eq("divu_hi", 64'(w_hi_x), 64'd2);
      check_eq("divu_lo", 64'(w_lo_x), 64'd14);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
